// File: rtl/fht_transform_ram.sv
// fht_transform_ram: ping-pong working memory for the FHT datapath (load, butterfly stages, unload)
module fht_transform_ram #(
  parameter int N = 256,
  parameter int DATA_W = 16,
  parameter bit BIT_REV = 1'b1,
  localparam int AW = $clog2(N),
  localparam int SW = $clog2(AW) + 1
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iLOAD_VALID,
  input  logic [DATA_W-1:0] iLOAD_DATA,
  output logic              oLOAD_READY,
  input  logic [AW-1:0]     iCALC_RD_ADDR,
  output logic [DATA_W-1:0] oCALC_RD_DATA,
  input  logic              iCALC_WR_EN,
  input  logic [AW-1:0]     iCALC_WR_ADDR,
  input  logic [DATA_W-1:0] iCALC_WR_DATA,
  input  logic              iCALC_DONE,
  output logic [SW-1:0]     oSTAGE,
  output logic              oUNLOAD_VALID,
  output logic [DATA_W-1:0] oUNLOAD_DATA,
  output logic              oUNLOAD_LAST,
  input  logic              iUNLOAD_READY,
  output logic [1:0]        oSTATE,
  output logic              oERR
);
  typedef enum logic [1:0] {LOAD = 2'd0, CALC = 2'd1, UNLOAD = 2'd2} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] bank0 [N];
  logic [DATA_W-1:0] bank1 [N];
  logic [DATA_W-1:0] rd_q;
  logic [AW-1:0] k, u, a_addr, ld_addr;
  logic [SW-1:0] stage;
  logic sel, u_done, a_valid, valid, last, err;
  logic ld_hs, calc, calc_we, calc_done, last_stage, adv, ul_end;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    for (int i = 0; i < AW; i++) bitrev[i] = a[AW-1-i];
  endfunction

  // handshake qualifiers and next-state selection
  always_comb begin
    ld_hs = iLOAD_VALID && state == LOAD;
    calc = state == CALC;
    calc_we = iCALC_WR_EN && calc;
    calc_done = iCALC_DONE && calc;
    last_stage = stage == SW'(AW - 1);
    adv = !valid || iUNLOAD_READY;
    ul_end = valid && last && iUNLOAD_READY;
    ld_addr = BIT_REV ? bitrev(k) : k;
    state_nx = (ld_hs && k == AW'(N - 1)) ? CALC :
               (calc_done && last_stage) ? UNLOAD :
               ul_end ? LOAD : state;
  end

  // controller state, counters, unload pipeline and sticky error
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state <= LOAD;
      k <= '0;
      sel <= 1'b0;
      stage <= '0;
      u <= '0;
      u_done <= 1'b0;
      a_valid <= 1'b0;
      a_addr <= '0;
      valid <= 1'b0;
      last <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      err <= err || ((iCALC_WR_EN || iCALC_DONE) && !calc) || (iLOAD_VALID && state != LOAD);
      if (ld_hs) k <= k + 1'b1;
      if (calc_done) begin
        sel <= !sel;
        stage <= last_stage ? '0 : stage + 1'b1;
      end
      if (state == UNLOAD) begin
        if (ul_end) begin
          valid <= 1'b0;
          last <= 1'b0;
          a_valid <= 1'b0;
          u <= '0;
          u_done <= 1'b0;
          sel <= 1'b0;
        end else if (adv) begin
          a_valid <= !u_done;
          a_addr <= u;
          if (!u_done) begin
            u <= u + 1'b1;
            u_done <= u == AW'(N - 1);
          end
          valid <= a_valid;
          last <= a_valid && a_addr == AW'(N - 1);
        end
      end
    end
  end

  // shared read register: butterfly reads in CALC, result stream in UNLOAD (held on stall)
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) rd_q <= '0;
    else if (calc) rd_q <= sel ? bank1[iCALC_RD_ADDR] : bank0[iCALC_RD_ADDR];
    else if (state == UNLOAD && adv) rd_q <= sel ? bank1[a_addr] : bank0[a_addr];
  end

  // bank writes: load always targets bank 0, butterfly writes target the bank not being read
  always_ff @(posedge iCLK) begin
    if (ld_hs || (calc_we && sel)) bank0[ld_hs ? ld_addr : iCALC_WR_ADDR] <= ld_hs ? iLOAD_DATA : iCALC_WR_DATA;
    if (calc_we && !sel) bank1[iCALC_WR_ADDR] <= iCALC_WR_DATA;
  end

  assign oLOAD_READY = state == LOAD;
  assign oSTATE = state;
  assign oSTAGE = stage;
  assign oCALC_RD_DATA = rd_q;
  assign oUNLOAD_DATA = rd_q;
  assign oUNLOAD_VALID = valid;
  assign oUNLOAD_LAST = last;
  assign oERR = err;
endmodule

// File: tb/tb_fht_transform_ram.sv
// tb_fht_transform_ram: randomized checks of load, ping-pong stages and unload against a bank model
module tb_fht_transform_ram;
  localparam int N = 8, DW = 16, AW = 3, SW = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic load_valid = 1'b0, load_ready;
  logic [DW-1:0] load_data = '0;
  logic [AW-1:0] rd_addr = '0, wr_addr = '0;
  logic [DW-1:0] rd_data, wr_data = '0, ul_data;
  logic wr_en = 1'b0, calc_done = 1'b0;
  logic [SW-1:0] stage;
  logic ul_valid, ul_last, ul_ready = 1'b0, err;
  logic [1:0] state;
  int vectors = 0, errors = 0;
  logic [DW-1:0] mdl [2][N];
  bit known [2][N];
  logic [DW-1:0] ldv [N];
  int msel = 0, mstage = 0;

  always #5 clk = ~clk;

  fht_transform_ram #(.N(N), .DATA_W(DW), .BIT_REV(1'b1)) dut (
    .iCLK(clk), .iRESET(rst), .iLOAD_VALID(load_valid), .iLOAD_DATA(load_data), .oLOAD_READY(load_ready),
    .iCALC_RD_ADDR(rd_addr), .oCALC_RD_DATA(rd_data), .iCALC_WR_EN(wr_en), .iCALC_WR_ADDR(wr_addr),
    .iCALC_WR_DATA(wr_data), .iCALC_DONE(calc_done), .oSTAGE(stage), .oUNLOAD_VALID(ul_valid),
    .oUNLOAD_DATA(ul_data), .oUNLOAD_LAST(ul_last), .iUNLOAD_READY(ul_ready), .oSTATE(state), .oERR(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int brev(input int k);
    int r = 0;
    for (int i = 0; i < AW; i++) begin
      r = r * 2 + k % 2;
      k = k / 2;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, load_ready, 1);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_stage"}, stage, 0);
    chk({tag, "_rd"}, rd_data, 0);
    chk({tag, "_valid"}, ul_valid, 0);
    chk({tag, "_data"}, ul_data, 0);
    chk({tag, "_last"}, ul_last, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic load(input bit gaps);
    for (int k = 0; k < N; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      chk($sformatf("ld_ready%0d", k), load_ready, 1);
      load_valid = 1'b1;
      load_data = ldv[k];
      tick();
      load_valid = 1'b0;
      mdl[0][brev(k)] = ldv[k];
      known[0][brev(k)] = 1'b1;
    end
    chk("ld_ready_after", load_ready, 0);
    chk("ld_state_after", state, 1);
    chk("ld_stage_after", stage, 0);
    msel = 0;
    mstage = 0;
  endtask

  task automatic random_load_values();
    for (int k = 0; k < N; k++) ldv[k] = DW'($urandom);
  endtask

  task automatic run_stage(input logic [N-1:0] wmask, input bit rnd);
    logic [DW-1:0] exp, wd;
    for (int a = 0; a < N; a++) begin
      rd_addr = AW'(a);
      tick();
      exp = mdl[msel][a];
      if (known[msel][a]) chk($sformatf("rd_s%0d_a%0d", mstage, a), rd_data, exp);
      if (wmask[a]) begin
        wd = rnd ? DW'($urandom) : exp + 1'b1;
        wr_en = 1'b1;
        wr_addr = AW'(a);
        wr_data = wd;
        tick();
        wr_en = 1'b0;
        mdl[1-msel][a] = wd;
        known[1-msel][a] = 1'b1;
      end
    end
  endtask

  task automatic done_pulse(input bit wr, input int addr, input logic [DW-1:0] d);
    calc_done = 1'b1;
    if (wr) begin
      wr_en = 1'b1;
      wr_addr = AW'(addr);
      wr_data = d;
      mdl[1-msel][addr] = d;
      known[1-msel][addr] = 1'b1;
    end
    tick();
    calc_done = 1'b0;
    wr_en = 1'b0;
    msel = 1 - msel;
    if (mstage == AW - 1) begin
      mstage = 0;
      chk("done_state", state, 2);
    end else begin
      mstage++;
      chk("done_state", state, 1);
    end
    chk("done_stage", stage, mstage);
  endtask

  task automatic unload(input int pat, input int abort);
    int idx = 0, cyc = 0;
    bit r;
    ul_ready = 1'b0;
    chk("ul_lat0", ul_valid, 0);
    tick();
    chk("ul_lat1", ul_valid, 0);
    tick();
    chk("ul_lat2", ul_valid, 1);
    while (idx < N && cyc < 200) begin
      r = pat == 0 ? (cyc % 4 == 0 || cyc % 4 == 3) : pat == 1 ? 1'($urandom) : 1'b1;
      ul_ready = r;
      chk($sformatf("ul_valid%0d", idx), ul_valid, 1);
      chk($sformatf("ul_data%0d", idx), ul_data, mdl[msel][idx]);
      chk($sformatf("ul_last%0d", idx), ul_last, idx == N - 1);
      if (r) idx++;
      tick();
      cyc++;
      if (abort != 0 && idx == abort) return;
    end
    ul_ready = 1'b0;
    chk("ul_count", idx, N);
    chk("ul_end_state", state, 0);
    chk("ul_end_ready", load_ready, 1);
    chk("ul_end_valid", ul_valid, 0);
    msel = 0;
  endtask

  task automatic full_transform(input int pat);
    random_load_values();
    load(1'b1);
    for (int s = 0; s < AW; s++) begin
      run_stage(N'($urandom), 1'b1);
      done_pulse(1'b0, 0, '0);
    end
    unload(pat, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) tick();
    check_reset_values("rst_held");
    rst = 1'b0;
    tick();
    check_reset_values("rst_rel");
    // bit-reversed load of 0..7, then three +1 stages and a 1,0,0,1 unload
    for (int k = 0; k < N; k++) ldv[k] = DW'(k);
    load(1'b0);
    for (int s = 0; s < AW; s++) begin
      run_stage('1, 1'b0);
      done_pulse(1'b0, 0, '0);
    end
    chk("pp_result0", mdl[msel][1], 16'd7);
    chk("pp_err", err, 0);
    unload(0, 0);
    // write and done on the same cycle land in the pre-swap write bank
    random_load_values();
    load(1'b1);
    done_pulse(1'b1, 3, 16'hABCD);
    rd_addr = 3'd3;
    tick();
    chk("simul_wr_done", rd_data, 16'hABCD);
    run_stage('1, 1'b1);
    done_pulse(1'b0, 0, '0);
    run_stage('1, 1'b1);
    done_pulse(1'b0, 0, '0);
    unload(1, 0);
    // protocol errors: butterfly strobes during LOAD, load sample during CALC
    chk("err_clear", err, 0);
    wr_en = 1'b1;
    wr_addr = 3'd0;
    wr_data = 16'h5555;
    calc_done = 1'b1;
    tick();
    wr_en = 1'b0;
    calc_done = 1'b0;
    chk("err_set", err, 1);
    chk("err_stage", stage, 0);
    chk("err_state", state, 0);
    random_load_values();
    load(1'b0);
    load_valid = 1'b1;
    load_data = 16'hFFFF;
    tick();
    load_valid = 1'b0;
    chk("err_drop_state", state, 1);
    run_stage(8'hFE, 1'b0);
    done_pulse(1'b0, 0, '0);
    run_stage('1, 1'b0);
    done_pulse(1'b0, 0, '0);
    chk("err_sticky", err, 1);
    run_stage('1, 1'b1);
    done_pulse(1'b0, 0, '0);
    unload(1, 0);
    chk("err_sticky2", err, 1);
    // asynchronous reset after three unload beats
    random_load_values();
    load(1'b1);
    for (int s = 0; s < AW; s++) begin
      run_stage('1, 1'b1);
      done_pulse(1'b0, 0, '0);
    end
    unload(2, 3);
    chk("rst_mid_valid_before", ul_valid, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", ul_valid, 0);
    chk("rst_mid_state", state, 0);
    chk("rst_mid_ready", load_ready, 1);
    chk("rst_mid_err", err, 0);
    msel = 0;
    mstage = 0;
    tick();
    rst = 1'b0;
    tick();
    check_reset_values("rst_mid_rel");
    repeat (3) full_transform(1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
